sd_response_receiver: RTL and testbench

SD_RESPONSE_RECEIVER -- requirements
Module: sd_response_receiver

---
 rtl/sd_response_receiver.sv | 114 +++++++++++
 tb/tb_sd_response_receiver.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sd_response_receiver.sv
// SD command-response receiver: waits for the start bit, shifts in a 48-bit
// R1-style frame MSB first, checks CRC7 and framing, reports the result or an NCR timeout.
module sd_response_receiver #(
  parameter int TIMEOUT    = 64,
  parameter int FRAME_BITS = 48
) (
  input  logic        iSD_clock,
  input  logic        iReset,
  input  logic        iEnable,
  input  logic        iStart,
  input  logic        iSerial,
  output logic [5:0]  oIndex,
  output logic [31:0] oArgument,
  output logic        oValid,
  output logic        oCrc_error,
  output logic        oFrame_error,
  output logic        oTimeout,
  output logic        oBusy
);

  localparam int CW = $clog2(FRAME_BITS);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    RECEIVE    = 2'd2,
    DONE       = 2'd3
  } state_t;

  state_t                  state;
  logic [WW-1:0]           wait_cnt;
  logic [CW-1:0]           bit_cnt;
  logic [FRAME_BITS-2:0]   shift;
  logic [6:0]              crc;

  // Serial CRC7, generator x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  assign oBusy = (state != IDLE);

  always_ff @(posedge iSD_clock) begin
    if (!iReset) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      crc          <= '0;
      oIndex       <= '0;
      oArgument    <= '0;
      oValid       <= 1'b0;
      oCrc_error   <= 1'b0;
      oFrame_error <= 1'b0;
      oTimeout     <= 1'b0;
    end else if (iEnable) begin
      case (state)
        IDLE: begin
          if (iStart) begin
            state    <= WAIT_START;
            wait_cnt <= '0;
            shift    <= '0;
            crc      <= '0;
          end
        end

        WAIT_START: begin
          if (!iSerial) begin
            shift   <= {shift[FRAME_BITS-3:0], iSerial};
            crc     <= crc7_step(crc, iSerial);
            bit_cnt <= CW'(FRAME_BITS - 2);
            state   <= RECEIVE;
          end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
            // DONE doubles as the one-cycle pulse state so iStart here is ignored.
            oTimeout <= 1'b1;
            state    <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        RECEIVE: begin
          if (bit_cnt == '0) begin
            // shift holds frame bits 47:1; iSerial is the end bit.
            oIndex       <= shift[44:39];
            oArgument    <= shift[38:7];
            oCrc_error   <= (crc != shift[6:0]);
            oFrame_error <= shift[45] | ~iSerial;
            oValid       <= 1'b1;
            state        <= DONE;
          end else begin
            shift   <= {shift[FRAME_BITS-3:0], iSerial};
            if (bit_cnt >= CW'(8)) begin
              crc <= crc7_step(crc, iSerial);
            end
            bit_cnt <= bit_cnt - 1'b1;
          end
        end

        DONE: begin
          oValid   <= 1'b0;
          oTimeout <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_response_receiver.sv
// Directed bench for sd_response_receiver: frame table plus timeout and mid-frame reset sequences.
module tb_sd_response_receiver;

  logic        clk = 1'b0;
  logic        rst_n, en, start, ser;
  logic [5:0]  idx;
  logic [31:0] arg;
  logic        vld, crc_err, frm_err, tmo, busy;

  int total = 0;
  int bad   = 0;
  int valid_cnt = 0;
  int to_cnt    = 0;
  bit overlap   = 1'b0;

  always #5 clk = ~clk;

  sd_response_receiver #(.TIMEOUT(64), .FRAME_BITS(48)) dut (
    .iSD_clock    (clk),
    .iReset       (rst_n),
    .iEnable      (en),
    .iStart       (start),
    .iSerial      (ser),
    .oIndex       (idx),
    .oArgument    (arg),
    .oValid       (vld),
    .oCrc_error   (crc_err),
    .oFrame_error (frm_err),
    .oTimeout     (tmo),
    .oBusy        (busy)
  );

  always @(negedge clk) begin
    if (vld) valid_cnt++;
    if (tmo) to_cnt++;
    if (vld && tmo) overlap = 1'b1;
  end

  typedef struct {
    string       name;
    logic [47:0] frame;
    int          stall_after;
    int          exp_lat;
    logic [5:0]  idx;
    logic [31:0] arg;
    logic        crc;
    logic        frm;
  } vec_t;

  vec_t vecs[4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // iStart, three idle-high cycles, then the frame MSB first; optional 5-cycle enable stall.
  task automatic send_frame(input logic [47:0] f, input int stall_after, output int lat);
    int steps;
    steps = 0;
    lat   = -1;
    start = 1'b1; ser = 1'b1;
    step(); steps++;
    start = 1'b0;
    repeat (3) begin
      step(); steps++;
      if (vld && lat < 0) lat = steps;
    end
    for (int i = 47; i >= 0; i--) begin
      ser = f[i];
      step(); steps++;
      if (vld && lat < 0) lat = steps;
      if (47 - i == stall_after) begin
        en = 1'b0;
        repeat (5) begin
          step(); steps++;
          if (vld && lat < 0) lat = steps;
        end
        en = 1'b1;
      end
    end
    ser = 1'b1;
  endtask

  initial begin
    int lat;
    int v0;
    int t0;
    bit early;
    logic [47:0] good;

    good = 48'h11_0000_0900_67;
    vecs[0] = '{"good",    48'h11_0000_0900_67, -1, 52, 6'h11, 32'h0000_0900, 1'b0, 1'b0};
    vecs[1] = '{"crc_bad", 48'h11_0000_0900_65, -1, 52, 6'h11, 32'h0000_0900, 1'b1, 1'b0};
    vecs[2] = '{"end_bit", 48'h11_0000_0900_66, -1, 52, 6'h11, 32'h0000_0900, 1'b0, 1'b1};
    vecs[3] = '{"stall",   48'h11_0000_0900_67, 20, 57, 6'h11, 32'h0000_0900, 1'b0, 1'b0};

    rst_n = 1'b0; en = 1'b1; start = 1'b0; ser = 1'b1;
    step(); step();
    check("rst_index", idx, 0);
    check("rst_arg", arg, 0);
    check("rst_valid", vld, 0);
    check("rst_crc", crc_err, 0);
    check("rst_frm", frm_err, 0);
    check("rst_tmo", tmo, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    step();

    // A low CMD line while idle must not start a capture.
    ser = 1'b0;
    repeat (4) step();
    check("idle_zero_busy", busy, 0);
    check("idle_zero_valid", vld, 0);
    ser = 1'b1;
    step();

    for (int k = 0; k < 4; k++) begin
      v0 = valid_cnt;
      send_frame(vecs[k].frame, vecs[k].stall_after, lat);
      check({vecs[k].name, "_lat"}, lat, vecs[k].exp_lat);
      check({vecs[k].name, "_index"}, idx, vecs[k].idx);
      check({vecs[k].name, "_arg"}, arg, vecs[k].arg);
      check({vecs[k].name, "_crc"}, crc_err, vecs[k].crc);
      check({vecs[k].name, "_frm"}, frm_err, vecs[k].frm);
      // iStart coinciding with oValid is dropped.
      start = 1'b1;
      step();
      start = 1'b0;
      check({vecs[k].name, "_valid_off"}, vld, 0);
      check({vecs[k].name, "_start_ignored"}, busy, 0);
      check({vecs[k].name, "_one_pulse"}, valid_cnt - v0, 1);
      repeat (3) step();
      check({vecs[k].name, "_index_hold"}, idx, vecs[k].idx);
    end

    // NCR timeout.
    v0 = valid_cnt; t0 = to_cnt; early = 1'b0;
    start = 1'b1; ser = 1'b1;
    step();
    start = 1'b0;
    repeat (63) begin
      step();
      if (tmo) early = 1'b1;
    end
    check("tmo_early", early, 0);
    step();
    check("tmo_pulse", tmo, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("tmo_off", tmo, 0);
    check("tmo_busy", busy, 0);
    check("tmo_count", to_cnt - t0, 1);
    check("tmo_no_valid", valid_cnt - v0, 0);
    repeat (2) step();

    // Reset in the middle of a frame.
    v0 = valid_cnt;
    start = 1'b1; ser = 1'b1;
    step();
    start = 1'b0;
    for (int i = 47; i > 17; i--) begin
      ser = good[i];
      step();
    end
    rst_n = 1'b0;
    step(); step();
    check("mid_rst_index", idx, 0);
    check("mid_rst_busy", busy, 0);
    rst_n = 1'b1;
    for (int i = 17; i >= 0; i--) begin
      ser = good[i];
      step();
    end
    ser = 1'b1;
    repeat (3) step();
    check("mid_rst_no_valid", valid_cnt - v0, 0);
    check("mid_rst_idle", busy, 0);
    send_frame(good, -1, lat);
    check("after_rst_lat", lat, 52);
    check("after_rst_index", idx, 6'h11);
    check("after_rst_arg", arg, 32'h0000_0900);
    check("after_rst_crc", crc_err, 0);
    check("after_rst_frm", frm_err, 0);
    step();
    check("after_rst_count", valid_cnt - v0, 1);

    check("valid_tmo_overlap", overlap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
